// File: rtl/gpio_pad_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_pad_ctrl
// Core-side controller for NPINS bidirectional pad cells with gated pulls.
// Drives pad A / EN / PUEN / PDEN (EN, PUEN, PDEN active-low) from the GPIO
// register file. Synchronises and (optionally) debounces pad Y into gpio_in,
// and raises sticky per-pin edge interrupts.
//
// Build option:
//   GPIO_PAD_DEBOUNCE_EN  defined   -> per-pin debounce counters; a new level
//                                      is accepted after DB_CNT consecutive
//                                      differing synchronised samples.
//                         undefined -> gpio_in follows the synchroniser output
//                                      every cycle; DB_CNT is ignored.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   cfg_oe          1 = drive pad from cfg_out
//   cfg_out         output data
//   cfg_pu, cfg_pd  pull-up / pull-down requests (pull-up wins if both set)
//   cfg_irq_en      per-pin interrupt enable
//   cfg_irq_rise    1 = irq on rising gpio_in edge, 0 = on falling edge
//   irq_clr         one-cycle clear strobe for irq_status
//   pad_y           pad cell Y (asynchronous)
//   pad_a, pad_en   pad cell A and EN (0 = driving)
//   pad_puen        pad cell PUEN (0 = pull-up on)
//   pad_pden        pad cell PDEN (0 = pull-down on)
//   gpio_in         synchronised / debounced pad level
//   irq_status      sticky per-pin interrupt flags
//   irq             OR of irq_status
// ---------------------------------------------------------------------------
module gpio_pad_ctrl #(
    parameter int unsigned NPINS       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CNT      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPINS-1:0] cfg_oe,
    input  logic [NPINS-1:0] cfg_out,
    input  logic [NPINS-1:0] cfg_pu,
    input  logic [NPINS-1:0] cfg_pd,
    input  logic [NPINS-1:0] cfg_irq_en,
    input  logic [NPINS-1:0] cfg_irq_rise,
    input  logic [NPINS-1:0] irq_clr,
    input  logic [NPINS-1:0] pad_y,
    output logic [NPINS-1:0] pad_a,
    output logic [NPINS-1:0] pad_en,
    output logic [NPINS-1:0] pad_puen,
    output logic [NPINS-1:0] pad_pden,
    output logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] irq_status,
    output logic             irq
);

    // Illegal parameter values leave a clearly named marker block in the
    // elaborated hierarchy so they are easy to spot in any netlist review.
    if (SYNC_STAGES < 2) begin : g_illegal_sync_stages
    end
    if (DB_CNT < 1) begin : g_illegal_db_cnt
    end

    // ------------------------------------------------------------------
    // Output path: pulls are gated off while driving; pull-up beats
    // pull-down so both can never be on together.
    // ------------------------------------------------------------------
    logic [NPINS-1:0] pad_puen_d;
    logic [NPINS-1:0] pad_pden_d;

    always_comb begin
        pad_puen_d = ~(cfg_pu & ~cfg_oe);
        pad_pden_d = ~(cfg_pd & ~cfg_pu & ~cfg_oe);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_a    <= '0;
            pad_en   <= '1;
            pad_puen <= '1;
            pad_pden <= '1;
        end else begin
            pad_a    <= cfg_out;
            pad_en   <= ~cfg_oe;
            pad_puen <= pad_puen_d;
            pad_pden <= pad_pden_d;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser: SYNC_STAGES flops per pin.
    // ------------------------------------------------------------------
    logic [NPINS-1:0] sync_q [SYNC_STAGES];
    logic [NPINS-1:0] s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pad_y;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Level acceptance: commit[i] marks the cycle gpio_in[i] takes s[i].
    // ------------------------------------------------------------------
    logic [NPINS-1:0] commit;

`ifdef GPIO_PAD_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_CNT + 1);

    logic [CNT_W-1:0] cnt_q [NPINS];
    logic [CNT_W-1:0] cnt_d [NPINS];

    // Count consecutive differing samples; any agreement restarts the count.
    always_comb begin
        commit = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < int'(NPINS); i++) begin
            if (s[i] == gpio_in[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DB_CNT - 1)) begin
                commit[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NPINS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No filtering: every difference is accepted on the next edge.
    assign commit = s ^ gpio_in;
`endif

    // ------------------------------------------------------------------
    // gpio_in and sticky interrupts. The new level after a commit is s,
    // so an event fires when s matches the configured edge polarity.
    // A set in the same cycle as a clear takes priority.
    // ------------------------------------------------------------------
    logic [NPINS-1:0] gpio_in_d;
    logic [NPINS-1:0] irq_set;
    logic [NPINS-1:0] irq_status_d;

    always_comb begin
        gpio_in_d    = (commit & s) | (~commit & gpio_in);
        irq_set      = commit & cfg_irq_en & ~(s ^ cfg_irq_rise);
        irq_status_d = irq_set | (irq_status & ~irq_clr);
    end

    // irq is registered from the next-state OR, so it always equals the OR
    // of the irq_status flops and never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_in    <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            gpio_in    <= gpio_in_d;
            irq_status <= irq_status_d;
            irq        <= |irq_status_d;
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl. A window-based model predicts every
// output each cycle; directed steps add hand-computed literal expectations.
module tb_gpio_pad_ctrl;

    localparam int unsigned NPINS = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DBC   = 4;
`ifdef GPIO_PAD_DEBOUNCE_EN
    localparam int unsigned WIN   = DBC;
    localparam int          LAT   = 6;   // hand value: 2 sync + 4 debounce
    localparam logic        SHORT_PASSES = 1'b0;
`else
    localparam int unsigned WIN   = 1;
    localparam int          LAT   = 3;   // hand value: 2 sync + 1
    localparam logic        SHORT_PASSES = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NPINS-1:0] cfg_oe, cfg_out, cfg_pu, cfg_pd;
    logic [NPINS-1:0] cfg_irq_en, cfg_irq_rise, irq_clr, pad_y;
    logic [NPINS-1:0] pad_a, pad_en, pad_puen, pad_pden, gpio_in, irq_status;
    logic             irq;

    int tests_run = 0;
    int tests_failed = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(.NPINS(NPINS), .SYNC_STAGES(SYNC), .DB_CNT(DBC)) dut (
        .clk(clk), .reset(reset),
        .cfg_oe(cfg_oe), .cfg_out(cfg_out), .cfg_pu(cfg_pu), .cfg_pd(cfg_pd),
        .cfg_irq_en(cfg_irq_en), .cfg_irq_rise(cfg_irq_rise), .irq_clr(irq_clr),
        .pad_y(pad_y),
        .pad_a(pad_a), .pad_en(pad_en), .pad_puen(pad_puen), .pad_pden(pad_pden),
        .gpio_in(gpio_in), .irq_status(irq_status), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: hist[j] is the pad_y word sampled j edges ago. A pin accepts
    // the opposite level when the WIN synchronised samples seen before this
    // edge (pad samples SYNC..SYNC+WIN-1 edges back) all differ from it.
    // ------------------------------------------------------------------
    logic [NPINS-1:0] hist [SYNC+WIN];
    logic [NPINS-1:0] m_a, m_en, m_pu, m_pd, m_gpio, m_irq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < int'(SYNC+WIN); j++) hist[j] = '0;
            m_a = '0; m_en = '1; m_pu = '1; m_pd = '1; m_gpio = '0; m_irq = '0;
        end else begin
            for (int j = int'(SYNC+WIN) - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = pad_y;
            for (int i = 0; i < int'(NPINS); i++) begin
                logic all_diff;
                logic set;
                all_diff = 1'b1;
                set = 1'b0;
                for (int j = int'(SYNC); j < int'(SYNC+WIN); j++)
                    if (hist[j][i] == m_gpio[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_gpio[i] = ~m_gpio[i];
                    set = cfg_irq_en[i] && (m_gpio[i] == cfg_irq_rise[i]);
                end
                m_irq[i] = set || (m_irq[i] && !irq_clr[i]);
                m_a[i]  = cfg_out[i];
                m_en[i] = !cfg_oe[i];
                m_pu[i] = !(cfg_pu[i] && !cfg_oe[i]);
                m_pd[i] = !(cfg_pd[i] && !cfg_pu[i] && !cfg_oe[i]);
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pad_a", 32'(pad_a), 32'(m_a));
            check("pad_en", 32'(pad_en), 32'(m_en));
            check("pad_puen", 32'(pad_puen), 32'(m_pu));
            check("pad_pden", 32'(pad_pden), 32'(m_pd));
            check("gpio_in", 32'(gpio_in), 32'(m_gpio));
            check("irq_status", 32'(irq_status), 32'(m_irq));
            check("irq", 32'(irq), 32'(|m_irq));
        end
    end

    task automatic drive_slot();
        @(negedge clk);
        #1;
    endtask

    // Counts rising edges until gpio_in[pin]==lvl; bounded at 20.
    task automatic wait_gpio(input int pin, input logic lvl, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (gpio_in[pin] !== lvl && edges < 20);
    endtask

    // Holds pad_y[pin] high across exactly len rising edges, then reports
    // whether gpio_in[pin] was ever seen high in the following 12 edges.
    task automatic pulse(input int pin, input int len, output logic seen);
        seen = 1'b0;
        drive_slot();
        pad_y[pin] = 1'b1;
        repeat (len) @(posedge clk);
        drive_slot();
        pad_y[pin] = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (gpio_in[pin] === 1'b1) seen = 1'b1;
        end
    endtask

    logic [NPINS-1:0] vec_oe  [4] = '{16'hF0F0, 16'h0FF0, 16'h0000, 16'hFFFF};
    logic [NPINS-1:0] vec_out [4] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h1234};
    logic [NPINS-1:0] vec_pu  [4] = '{16'hCCCC, 16'hFF00, 16'h3333, 16'hFFFF};
    logic [NPINS-1:0] vec_pd  [4] = '{16'hAAAA, 16'hF0F0, 16'hFFFF, 16'hFFFF};
    logic [NPINS-1:0] vec_y   [4] = '{16'h00FF, 16'hFF00, 16'h0F0F, 16'h0000};

    initial begin
        int n;
        logic seen;
        reset = 1'b1;
        cfg_oe = '0; cfg_out = '0; cfg_pu = '0; cfg_pd = '0;
        cfg_irq_en = '0; cfg_irq_rise = '0; irq_clr = '0; pad_y = '0;
        repeat (3) @(negedge clk);
        check("rst_pad_en", 32'(pad_en), 32'h0000FFFF);
        check("rst_pad_puen", 32'(pad_puen), 32'h0000FFFF);
        check("rst_pad_pden", 32'(pad_pden), 32'h0000FFFF);
        check("rst_pad_a", 32'(pad_a), 32'h0);
        check("rst_gpio_in", 32'(gpio_in), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // Drive pin 0 with pull-up requested: pull stays off.
        drive_slot();
        cfg_oe = 16'h0001; cfg_out = 16'h0001; cfg_pu = 16'h0001;
        @(posedge clk); #1;
        check("oe_pad_en", 32'(pad_en), 32'h0000FFFE);
        check("oe_pad_a", 32'(pad_a), 32'h00000001);
        check("oe_pull_suppressed", 32'(pad_puen), 32'h0000FFFF);

        // Pin 3 both pulls (up wins), pin 4 pull-down, pin 0 driving.
        drive_slot();
        cfg_pu = 16'h0009; cfg_pd = 16'h0019;
        @(posedge clk); #1;
        check("pull_puen", 32'(pad_puen), 32'h0000FFF7);
        check("pull_pden", 32'(pad_pden), 32'h0000FFEF);

        // Stable rise on pin 5, then a 3-cycle glitch.
        drive_slot();
        pad_y[5] = 1'b1;
        wait_gpio(5, 1'b1, n);
        check("rise_latency_pin5", 32'(n), 32'(LAT));
        drive_slot();
        pad_y[5] = 1'b0;
        wait_gpio(5, 1'b0, n);
        check("fall_latency_pin5", 32'(n), 32'(LAT));
        pulse(5, 3, seen);
        check("pulse3_pin5", 32'(seen), 32'(SHORT_PASSES));

        // Pin 2: rise latency and a 1-cycle pulse.
        drive_slot();
        pad_y[2] = 1'b1;
        wait_gpio(2, 1'b1, n);
        check("rise_latency_pin2", 32'(n), 32'(LAT));
        drive_slot();
        pad_y[2] = 1'b0;
        wait_gpio(2, 1'b0, n);
        pulse(2, 1, seen);
        check("pulse1_pin2", 32'(seen), 32'(SHORT_PASSES));

        // Falling-edge interrupt on pin 7.
        drive_slot();
        cfg_irq_en[7] = 1'b1; cfg_irq_rise[7] = 1'b0; pad_y[7] = 1'b1;
        wait_gpio(7, 1'b1, n);
        check("irq_rise_ignored", 32'(irq), 32'h0);
        drive_slot();
        pad_y[7] = 1'b0;
        wait_gpio(7, 1'b0, n);
        check("irq_fall_latency", 32'(n), 32'(LAT));
        check("irq_fall_status", 32'(irq_status), 32'h00000080);
        check("irq_fall_irq", 32'(irq), 32'h1);
        drive_slot();
        cfg_irq_en[7] = 1'b0;
        @(posedge clk); #1;
        check("irq_en_off_keeps", 32'(irq_status), 32'h00000080);
        drive_slot();
        irq_clr[7] = 1'b1;
        @(posedge clk); #1;
        check("irq_clr_status", 32'(irq_status), 32'h0);
        check("irq_clr_irq", 32'(irq), 32'h0);
        drive_slot();
        irq_clr[7] = 1'b0; cfg_irq_en[7] = 1'b1; pad_y[7] = 1'b1;
        wait_gpio(7, 1'b1, n);
        drive_slot();
        pad_y[7] = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        drive_slot();
        irq_clr[7] = 1'b1;
        @(posedge clk); #1;
        check("set_beats_clr_gpio", 32'(gpio_in[7]), 32'h0);
        check("set_beats_clr_status", 32'(irq_status), 32'h00000080);
        drive_slot();
        irq_clr[7] = 1'b0;

        // Reset in the middle of a rising acceptance on pin 9.
        cfg_irq_en[9] = 1'b1; cfg_irq_rise[9] = 1'b1; pad_y[9] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_gpio_in", 32'(gpio_in), 32'h0);
        check("midrst_irq_status", 32'(irq_status), 32'h0);
        drive_slot();
        reset = 1'b0;
        wait_gpio(9, 1'b1, n);
        check("postrst_latency", 32'(n), 32'(LAT));
        check("postrst_irq_status", 32'(irq_status), 32'h00000200);

        // Directed configuration / pad vectors, checked by the model.
        for (int v = 0; v < 4; v++) begin
            drive_slot();
            cfg_oe = vec_oe[v]; cfg_out = vec_out[v];
            cfg_pu = vec_pu[v]; cfg_pd = vec_pd[v];
            cfg_irq_en = 16'hFFFF; cfg_irq_rise = vec_out[v];
            irq_clr = vec_pd[v];
            pad_y = vec_y[v];
            repeat (2) @(posedge clk);
            drive_slot();
            irq_clr = '0;
            repeat (8) @(posedge clk);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
